// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls words from the TX FIFO (registered read port)
// and shifts them out as start / data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic             par_en_q, par_en_d;
   logic             par_q, par_d;
   logic             stop2_q, stop2_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d;
   logic             bit_end;

   assign bit_end    = (cnt_q == div_q);
   assign fifo_rd_en = (state_q == S_FETCH);
   assign busy       = (state_q != S_IDLE);
   assign tx         = tx_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_d      = bit_q;
      par_en_d   = par_en_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      frame_done = 1'b0;

      // Baud counter only runs while a bit is on the line.
      if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (tx_en && !fifo_empty) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            shift_d    = fifo_rdata;
            div_d      = baud_div;
            par_en_d   = parity_en;
            stop2_d    = stop2;
            par_d      = (^fifo_rdata) ^ parity_odd;
            cnt_d      = '0;
            bit_d      = '0;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b0;
            state_d    = S_START;
         end
         S_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == LAST_BIT) begin
                  tx_d    = par_en_q ? par_q : 1'b1;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  frame_done = 1'b1;
                  state_d    = (tx_en && !fifo_empty) ? S_FETCH : S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         par_en_q   <= par_en_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboarded bench: each queued word pushes an expected frame; a line monitor
// decodes tx cycle by cycle and compares against the popped entry.
module tb_uart_tx_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_en;
   logic [15:0] baud_div;
   logic        parity_en, parity_odd, stop2;
   logic        fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        fifo_rd_en, tx, busy, frame_done;

   uart_tx_serializer #(.WIDTH(8), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .baud_div(baud_div),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
      .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // FIFO model: main thread owns the write side, this block the registered read side.
   logic [7:0] fmem [0:63];
   int wp, rp;
   assign fifo_empty = (wp == rp);
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rdata <= fmem[rp % 64];
         rp         <= rp + 1;
      end
   end

   typedef struct {
      logic [7:0] d;
      logic       pe, po, s2, b2b;
      int         p;
   } exp_t;
   exp_t eq [0:63];
   int ewp, erp;

   int cyc, rd_cnt, rd_cyc, done_cnt, busy_fall;
   logic busy_d;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (fifo_rd_en) begin
         rd_cnt <= rd_cnt + 1;
         rd_cyc <= cyc;
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      busy_d <= busy;
      if (busy_d && !busy) busy_fall <= busy_fall + 1;
   end

   int nvec, nbad;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] w, input bit b2b);
      fmem[wp % 64] = w;
      wp++;
      eq[ewp % 64] = '{d: w, pe: parity_en, po: parity_odd, s2: stop2, b2b: b2b,
                       p: int'(baud_div) + 1};
      ewp++;
   endtask

   task automatic fpush(input logic [7:0] w);
      fmem[wp % 64] = w;
      wp++;
   endtask

   task automatic wait_rd(input int r0);
      int n;
      n = 0;
      while (rd_cnt == r0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (rd_cnt == r0) check("rd_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      int n;
      repeat (3) @(negedge clk);
      n = 0;
      while ((busy || erp != ewp) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy || erp != ewp) check("idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   // Line monitor: every cycle of the frame must match the expected bit.
   initial begin : mon
      exp_t        e;
      logic [11:0] expb, obs;
      int          n, len, glitch, dpos, done_last;
      bit          ab;
      done_last = -100;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            if (erp == ewp) begin
               check("unexpected_frame", 1, 0);
               for (int k = 0; k < 200 && tx === 1'b0; k++) @(negedge clk);
            end else begin
               e = eq[erp % 64];
               erp++;
               check("rd_to_start", cyc - rd_cyc, 2);
               if (e.b2b) check("b2b_gap", cyc - done_last - 1, 2);
               expb = '0;
               for (int i = 0; i < 8; i++) expb[1+i] = e.d[i];
               n = 9;
               if (e.pe) begin
                  expb[n] = (^e.d) ^ e.po;
                  n++;
               end
               expb[n] = 1'b1;
               n++;
               if (e.s2) begin
                  expb[n] = 1'b1;
                  n++;
               end
               len = n * e.p;
               glitch = 0;
               dpos = -1;
               obs = '0;
               ab = 1'b0;
               for (int c = 0; c < len; c++) begin
                  if (c > 0) @(negedge clk);
                  if (rst) begin
                     ab = 1'b1;
                     break;
                  end
                  if (tx !== expb[c / e.p]) glitch++;
                  if (c % e.p == e.p / 2) obs[c / e.p] = tx;
                  if (frame_done && dpos < 0) dpos = c;
               end
               if (!ab) begin
                  check("frame_bits", 32'(obs), 32'(expb));
                  check("bit_timing_glitches", glitch, 0);
                  check("frame_len", dpos + 1, len);
                  done_last = cyc;
               end
            end
         end
      end
   end

   initial begin : main
      int r0, d0, b0;
      rst = 1'b0; tx_en = 1'b0; baud_div = 16'd3;
      parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
      #1 rst = 1'b1;
      #3;
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_rd_en", fifo_rd_en, 0);
      check("reset_done", frame_done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset in the middle of DATA
      tx_en = 1'b1;
      r0 = rd_cnt;
      push(8'h3C, 1'b0);
      wait_rd(r0);
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midreset_tx", tx, 1);
      check("midreset_busy", busy, 0);
      check("midreset_rd_en", fifo_rd_en, 0);
      check("midreset_done", frame_done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      r0 = rd_cnt;
      repeat (20) @(negedge clk);
      check("no_fetch_when_empty", rd_cnt - r0, 0);
      check("idle_after_reset_busy", busy, 0);

      // 0xA5, 4 cycles per bit, no parity, one stop
      r0 = rd_cnt; d0 = done_cnt;
      push(8'hA5, 1'b0);
      wait_idle();
      check("a5_rd_count", rd_cnt - r0, 1);
      check("a5_done_count", done_cnt - d0, 1);

      // 0x07 with even/odd parity, then two stop bits
      baud_div = 16'd1; parity_en = 1'b1;
      parity_odd = 1'b0; push(8'h07, 1'b0); wait_idle();
      parity_odd = 1'b1; push(8'h07, 1'b0); wait_idle();
      parity_odd = 1'b0; stop2 = 1'b1; push(8'h07, 1'b0); wait_idle();
      parity_en = 1'b0; stop2 = 1'b0;

      // Three queued words back to back at 1 cycle per bit
      baud_div = 16'd0;
      r0 = rd_cnt; d0 = done_cnt; b0 = busy_fall;
      push(8'h11, 1'b0); push(8'h22, 1'b1); push(8'h33, 1'b1);
      wait_idle();
      check("b2b_rd_count", rd_cnt - r0, 3);
      check("b2b_done_count", done_cnt - d0, 3);
      check("b2b_busy_falls", busy_fall - b0, 1);

      // 0xFF at baud_div=0
      d0 = done_cnt;
      push(8'hFF, 1'b0);
      wait_idle();
      check("ff_done_count", done_cnt - d0, 1);

      // tx_en dropped and baud_div changed mid-frame
      baud_div = 16'd3;
      r0 = rd_cnt; d0 = done_cnt;
      push(8'h96, 1'b0);
      wait_rd(r0);
      repeat (10) @(negedge clk);
      tx_en = 1'b0;
      baud_div = 16'd7;
      fpush(8'h5A);
      wait_idle();
      repeat (30) @(negedge clk);
      check("txen_off_rd_count", rd_cnt - r0, 1);
      check("txen_off_done_count", done_cnt - d0, 1);
      check("txen_off_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
